// File: rtl/alu_uart_frame_bridge_if.sv
// Bus between the UART rx/tx cores, the ALU and the frame bridge.
// The bridge connects through the slave modport and its environment through master.
interface alu_uart_frame_bridge_if #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 6
);
  logic [7:0]        rx_data;
  logic              rx_done;
  logic              tx_done;
  logic [DATA_W-1:0] alu_res;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic              busy;
  logic              frame_done;
  logic              frame_err;
  logic              rx_ovr;

  modport master (
    output rx_data, rx_done, tx_done, alu_res,
    input  tx_start, tx_data, alu_a, alu_b, alu_op, busy, frame_done, frame_err, rx_ovr
  );

  modport slave (
    input  rx_data, rx_done, tx_done, alu_res,
    output tx_start, tx_data, alu_a, alu_b, alu_op, busy, frame_done, frame_err, rx_ovr
  );
endinterface

// File: rtl/alu_uart_frame_bridge.sv
// Collects little-endian operands A, B and an opcode from the rx byte stream, issues them
// to the ALU in one cycle, then returns the result LSB byte first through tx.
module alu_uart_frame_bridge #(
  parameter int DATA_W  = 16,
  parameter int OP_W    = 6,
  parameter int ALU_LAT = 1,
  parameter int TIMEOUT = 50000
) (
  input logic                    clk,
  input logic                    reset,
  alu_uart_frame_bridge_if.slave bus
);
  localparam int NB = DATA_W / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] BYTE_LAST = CW'(NB - 1);
  localparam logic [LW-1:0] LAT_LAST  = LW'(ALU_LAT - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic          TMO_EN    = (TIMEOUT > 0);

  typedef enum logic [2:0] {RX_A, RX_B, RX_OP, EXEC, TX_SEND, TX_WAIT} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     byte_cnt_q, byte_cnt_d;
  logic [LW-1:0]     lat_cnt_q, lat_cnt_d;
  logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [DATA_W-1:0] shadow_a_q, shadow_a_d;
  logic [DATA_W-1:0] shadow_b_q, shadow_b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_err_q, frame_err_d;
  logic              rx_ovr_q, rx_ovr_d;
  logic              tmo_active_s;
  logic              tmo_hit_s;

  // Next-state and next-output computation for the framing FSM.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    shadow_a_d   = shadow_a_q;
    shadow_b_d   = shadow_b_q;
    res_d        = res_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;

    // The idle timer only runs once a frame has started; an accepted byte always wins over expiry.
    tmo_active_s = ((state_q == RX_A) && (byte_cnt_q != '0)) || (state_q == RX_B) || (state_q == RX_OP);
    tmo_hit_s    = TMO_EN && tmo_active_s && !bus.rx_done && (tmo_cnt_q == TMO_LAST);
    if (TMO_EN && tmo_active_s && !bus.rx_done) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end else begin
      tmo_cnt_d = '0;
    end

    if (tmo_hit_s) begin
      state_d     = RX_A;
      byte_cnt_d  = '0;
      tmo_cnt_d   = '0;
      shadow_a_d  = '0;
      shadow_b_d  = '0;
      frame_err_d = 1'b1;
    end else begin
      case (state_q)
        RX_A, RX_B: begin
          if (bus.rx_done) begin
            if (state_q == RX_A) begin
              shadow_a_d[8*byte_cnt_q +: 8] = bus.rx_data;
            end else begin
              shadow_b_d[8*byte_cnt_q +: 8] = bus.rx_data;
            end
            if (byte_cnt_q == BYTE_LAST) begin
              byte_cnt_d = '0;
              state_d    = (state_q == RX_A) ? RX_B : RX_OP;
            end else begin
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
          end else begin
            byte_cnt_d = byte_cnt_q;
          end
        end
        RX_OP: begin
          if (bus.rx_done) begin
            alu_a_d   = shadow_a_q;
            alu_b_d   = shadow_b_q;
            alu_op_d  = bus.rx_data[OP_W-1:0];
            lat_cnt_d = '0;
            state_d   = EXEC;
          end else begin
            state_d = RX_OP;
          end
        end
        EXEC: begin
          if (lat_cnt_q == LAT_LAST) begin
            state_d = TX_SEND;
          end else begin
            lat_cnt_d = lat_cnt_q + 1'b1;
          end
        end
        TX_SEND: begin
          // The ALU result is valid from this cycle on; keep a copy for the later bytes.
          res_d      = bus.alu_res;
          tx_data_d  = bus.alu_res[7:0];
          tx_start_d = 1'b1;
          byte_cnt_d = '0;
          state_d    = TX_WAIT;
        end
        TX_WAIT: begin
          if (bus.tx_done) begin
            if (byte_cnt_q == BYTE_LAST) begin
              byte_cnt_d   = '0;
              frame_done_d = 1'b1;
              state_d      = RX_A;
            end else begin
              byte_cnt_d = byte_cnt_q + 1'b1;
              tx_data_d  = res_q[8*byte_cnt_d +: 8];
              tx_start_d = 1'b1;
            end
          end else begin
            state_d = TX_WAIT;
          end
        end
        default: begin
          state_d    = RX_A;
          byte_cnt_d = '0;
        end
      endcase
    end

    busy_d   = (state_d == EXEC) || (state_d == TX_SEND) || (state_d == TX_WAIT);
    rx_ovr_d = bus.rx_done && busy_q;
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RX_A;
      byte_cnt_q   <= '0;
      lat_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
      shadow_a_q   <= '0;
      shadow_b_q   <= '0;
      res_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_ovr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      shadow_a_q   <= shadow_a_d;
      shadow_b_q   <= shadow_b_d;
      res_q        <= res_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      rx_ovr_q     <= rx_ovr_d;
    end
  end

  assign bus.tx_start   = tx_start_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.rx_ovr     = rx_ovr_q;
endmodule

// File: tb/tb_alu_uart_frame_bridge.sv
// Directed bench for alu_uart_frame_bridge: a 16-bit instance and an 8-bit instance,
// each in front of an adder ALU that registers its result for one cycle.
module tb_alu_uart_frame_bridge;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_uart_frame_bridge_if #(.DATA_W(16), .OP_W(6)) b16 ();
  alu_uart_frame_bridge_if #(.DATA_W(8),  .OP_W(6)) b8 ();

  alu_uart_frame_bridge #(.DATA_W(16), .OP_W(6), .ALU_LAT(1), .TIMEOUT(100)) dut (
    .clk(clk), .reset(reset), .bus(b16.slave)
  );
  alu_uart_frame_bridge #(.DATA_W(8), .OP_W(6), .ALU_LAT(1), .TIMEOUT(100)) dut8 (
    .clk(clk), .reset(reset), .bus(b8.slave)
  );

  // Adder ALU models with one cycle of latency.
  always_ff @(posedge clk) begin
    b16.alu_res <= b16.alu_a + b16.alu_b;
    b8.alu_res  <= b8.alu_a + b8.alu_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    b16.rx_data = d;
    b16.rx_done = 1'b1;
    tick();
    b16.rx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a0, a1, bb0, bb1, op);
    send(a0); send(a1); send(bb0); send(bb1); send(op);
  endtask

  // Wait (bounded) for a tx_start pulse and check the byte it launches.
  task automatic wait_tx(input logic [7:0] exp, input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      if (b16.tx_start === 1'b1) seen = 1'b1;
      else tick();
    end
    chk({tag, "_seen"}, {31'd0, seen}, 32'd1);
    if (seen) chk(tag, {24'd0, b16.tx_data}, {24'd0, exp});
  endtask

  task automatic ack_tx();
    tick();
    tick();
    b16.tx_done = 1'b1;
    tick();
    b16.tx_done = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] a0, a1, bb0, bb1, op, r0, r1, input string tag);
    send_frame(a0, a1, bb0, bb1, op);
    wait_tx(r0, {tag, "_b0"});
    ack_tx();
    wait_tx(r1, {tag, "_b1"});
    ack_tx();
    chk({tag, "_done"}, {31'd0, b16.frame_done}, 32'd1);
    chk({tag, "_busy"}, {31'd0, b16.busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    b16.rx_data = 8'h00; b16.rx_done = 1'b0; b16.tx_done = 1'b0;
    b8.rx_data  = 8'h00; b8.rx_done  = 1'b0; b8.tx_done  = 1'b0;
    tick(); tick();
    chk("rst_tx_start", {31'd0, b16.tx_start}, 32'd0);
    chk("rst_alu_a", {16'd0, b16.alu_a}, 32'd0);
    chk("rst_busy", {31'd0, b16.busy}, 32'd0);
    reset = 1'b0;
    tick();

    // Basic frame with exact latency checks: 0x1234 + 0x0101 = 0x1335.
    send_frame(8'h34, 8'h12, 8'h01, 8'h01, 8'h20);
    chk("f1_alu_a", {16'd0, b16.alu_a}, 32'h1234);
    chk("f1_alu_b", {16'd0, b16.alu_b}, 32'h0101);
    chk("f1_alu_op", {26'd0, b16.alu_op}, 32'h20);
    chk("f1_busy", {31'd0, b16.busy}, 32'd1);
    chk("f1_start_c1", {31'd0, b16.tx_start}, 32'd0);
    tick();
    chk("f1_start_c2", {31'd0, b16.tx_start}, 32'd0);
    tick();
    chk("f1_start_c3", {31'd0, b16.tx_start}, 32'd1);
    chk("f1_data0", {24'd0, b16.tx_data}, 32'h35);
    tick();
    chk("f1_start_pulse", {31'd0, b16.tx_start}, 32'd0);
    chk("f1_data0_hold", {24'd0, b16.tx_data}, 32'h35);
    b16.tx_done = 1'b1; tick(); b16.tx_done = 1'b0;
    chk("f1_start_b1", {31'd0, b16.tx_start}, 32'd1);
    chk("f1_data1", {24'd0, b16.tx_data}, 32'h13);
    chk("f1_done_early", {31'd0, b16.frame_done}, 32'd0);
    tick();
    b16.tx_done = 1'b1; tick(); b16.tx_done = 1'b0;
    chk("f1_done", {31'd0, b16.frame_done}, 32'd1);
    chk("f1_busy_end", {31'd0, b16.busy}, 32'd0);
    tick();
    chk("f1_done_pulse", {31'd0, b16.frame_done}, 32'd0);

    // Timeout after one byte, then a clean frame: 0x00FF + 0x0001 = 0x0100.
    send(8'h34);
    repeat (99) tick();
    chk("to_err_c100", {31'd0, b16.frame_err}, 32'd0);
    tick();
    chk("to_err_c101", {31'd0, b16.frame_err}, 32'd1);
    tick();
    chk("to_err_pulse", {31'd0, b16.frame_err}, 32'd0);
    run_frame(8'hFF, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, "to_next");

    // Byte arriving on the last idle cycle is accepted.
    send(8'h34);
    repeat (99) tick();
    send(8'h12);
    chk("edge_err_a", {31'd0, b16.frame_err}, 32'd0);
    tick();
    chk("edge_err_b", {31'd0, b16.frame_err}, 32'd0);
    send(8'h01); send(8'h01); send(8'h20);
    chk("edge_alu_a", {16'd0, b16.alu_a}, 32'h1234);
    wait_tx(8'h35, "edge_b0");
    ack_tx();
    wait_tx(8'h13, "edge_b1");
    ack_tx();
    chk("edge_done", {31'd0, b16.frame_done}, 32'd1);

    // Overrun while waiting on tx: 0x0001 + 0x0002 = 0x0003.
    send_frame(8'h01, 8'h00, 8'h02, 8'h00, 8'h00);
    wait_tx(8'h03, "ovr_b0");
    tick();
    send(8'hAA);
    chk("ovr_pulse", {31'd0, b16.rx_ovr}, 32'd1);
    chk("ovr_data_hold", {24'd0, b16.tx_data}, 32'h03);
    tick();
    chk("ovr_pulse_end", {31'd0, b16.rx_ovr}, 32'd0);
    b16.tx_done = 1'b1; tick(); b16.tx_done = 1'b0;
    wait_tx(8'h00, "ovr_b1");
    ack_tx();
    chk("ovr_done", {31'd0, b16.frame_done}, 32'd1);
    run_frame(8'h10, 8'h00, 8'h20, 8'h00, 8'h00, 8'h30, 8'h00, "ovr_next");

    // Asynchronous reset while byte 0 is in flight.
    send_frame(8'h34, 8'h12, 8'h01, 8'h01, 8'h20);
    wait_tx(8'h35, "rst_b0");
    reset = 1'b1;
    #1;
    chk("mrst_tx_start", {31'd0, b16.tx_start}, 32'd0);
    chk("mrst_tx_data", {24'd0, b16.tx_data}, 32'd0);
    chk("mrst_alu_a", {16'd0, b16.alu_a}, 32'd0);
    chk("mrst_alu_b", {16'd0, b16.alu_b}, 32'd0);
    chk("mrst_alu_op", {26'd0, b16.alu_op}, 32'd0);
    chk("mrst_busy", {31'd0, b16.busy}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    run_frame(8'h02, 8'h00, 8'h03, 8'h00, 8'h01, 8'h05, 8'h00, "rst_next");

    // 8-bit instance: 0x07 + 0x08 = 0x0F, single result byte.
    b8.rx_data = 8'h07; b8.rx_done = 1'b1; tick();
    b8.rx_data = 8'h08; tick();
    b8.rx_data = 8'h01; tick();
    b8.rx_done = 1'b0;
    chk("w8_alu_op", {26'd0, b8.alu_op}, 32'h01);
    tick(); tick();
    chk("w8_start", {31'd0, b8.tx_start}, 32'd1);
    chk("w8_data", {24'd0, b8.tx_data}, 32'h0F);
    tick();
    b8.tx_done = 1'b1; tick(); b8.tx_done = 1'b0;
    chk("w8_done", {31'd0, b8.frame_done}, 32'd1);
    chk("w8_no_second", {31'd0, b8.tx_start}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
